// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer
// Narrows a 32-bit register value to a byte/half/word store: builds lane-replicated
// write data and byte enables, flags discarded significant bits, and queues the
// formatted request in a small FIFO between the MEM stage and data memory.
// Misaligned or reserved-size requests are consumed and reported, never enqueued.

module store_narrow_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_size,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_wdata,
    output logic [3:0]       out_be,
    output logic             out_trunc,
    output logic             misalign_err,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        trunc;
    } entry_t;

    // Replicate the narrowed value into every lane it could land in.
    function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SIZE_BYTE: w = {4{d[7:0]}};
            SIZE_HALF: w = {2{d[15:0]}};
            SIZE_WORD: w = d;
            default:   w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Byte enables, bit0 = lowest byte address of the word.
    function automatic logic [3:0] fmt_be(input logic [1:0] size, input logic [1:0] b);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << b;
            SIZE_HALF: be = b[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // True when the upper bits dropped by narrowing are not a pure extension.
    function automatic logic fmt_trunc(input logic [1:0] size, input logic [31:0] d,
                                       input logic sgn);
        logic t;
        case (size)
            SIZE_BYTE: t = sgn ? (d[31:8]  != {24{d[7]}})  : (d[31:8]  != 24'h00_0000);
            SIZE_HALF: t = sgn ? (d[31:16] != {16{d[15]}}) : (d[31:16] != 16'h0000);
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

    // Requests the memory cannot perform as a single aligned write.
    function automatic logic is_reject(input logic [1:0] size, input logic [1:0] b);
        logic r;
        case (size)
            SIZE_BYTE: r = 1'b0;
            SIZE_HALF: r = b[0];
            SIZE_WORD: r = (b != 2'b00);
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               misalign_r;

    entry_t             req_entry_s;
    entry_t             head_s;
    logic               reject_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;

    // Format the incoming request and derive the handshake qualifiers.
    always_comb begin
        req_entry_s       = '0;
        req_entry_s.addr  = {in_addr[31:2], 2'b00};
        req_entry_s.wdata = fmt_wdata(in_size, in_data);
        req_entry_s.be    = fmt_be(in_size, in_addr[1:0]);
        req_entry_s.trunc = fmt_trunc(in_size, in_data, in_signed);
        reject_s          = is_reject(in_size, in_addr[1:0]);
        full_s            = (count_r == CNT_W'(DEPTH));
        empty_s           = (count_r == {CNT_W{1'b0}});
        accept_s          = in_valid && !full_s;
        push_s            = accept_s && !reject_s;
        pop_s             = !empty_s && out_ready;
    end

    // Present the head entry, forcing zeros while the queue is empty.
    always_comb begin
        head_s = '0;
        if (!empty_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    // Entry storage; contents are only visible through a valid head, so no reset needed.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= req_entry_s;
        end
    end

    // Pointers, occupancy and the one-cycle reject pulse.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= accept_s && reject_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    assign in_ready     = !full_s;
    assign out_valid    = !empty_s;
    assign out_addr     = head_s.addr;
    assign out_wdata    = head_s.wdata;
    assign out_be       = head_s.be;
    assign out_trunc    = head_s.trunc;
    assign misalign_err = misalign_r;
    assign o_count      = count_r;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Directed self-checking bench for store_narrow_buffer.
module tb_store_narrow_buffer;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic [3:0]  out_be;
    logic        out_trunc;
    logic        misalign_err;
    logic [2:0]  o_count;

    int n_assert = 0;
    int n_fail   = 0;

    store_narrow_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_size(in_size), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_be(out_be), .out_trunc(out_trunc),
        .misalign_err(misalign_err), .o_count(o_count)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic sg);
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        in_size   = s;
        in_signed = sg;
    endtask

    initial begin
        Rst_n = 1'b0;
        out_ready = 1'b0;
        req(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        step();
        step();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_count", {29'h0, o_count}, 32'h0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
        chk("rst_wdata", out_wdata, 32'h0);
        chk("rst_addr", out_addr, 32'h0);
        Rst_n = 1'b1;
        step();

        // 1: store byte to lane 3
        req(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0);
        step();
        in_valid = 1'b0;
        chk("sb_valid", {31'h0, out_valid}, 32'h1);
        chk("sb_addr", out_addr, 32'h0000_1000);
        chk("sb_be", {28'h0, out_be}, 32'h8);
        chk("sb_wdata", out_wdata, 32'hABAB_ABAB);
        chk("sb_trunc", {31'h0, out_trunc}, 32'h0);
        chk("sb_count", {29'h0, o_count}, 32'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("sb_pop_valid", {31'h0, out_valid}, 32'h0);
        chk("sb_pop_count", {29'h0, o_count}, 32'h0);
        chk("empty_addr_zero", out_addr, 32'h0);
        chk("empty_be_zero", {28'h0, out_be}, 32'h0);

        // 2: store half, signed then unsigned
        req(1'b1, 32'h0000_2002, 32'hFFFF_8001, 2'b01, 1'b1);
        step();
        req(1'b1, 32'h0000_2002, 32'hFFFF_8001, 2'b01, 1'b0);
        step();
        in_valid = 1'b0;
        chk("sh_be", {28'h0, out_be}, 32'hC);
        chk("sh_wdata", out_wdata, 32'h8001_8001);
        chk("sh_signed_trunc", {31'h0, out_trunc}, 32'h0);
        chk("sh_count", {29'h0, o_count}, 32'h2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("sh_unsigned_trunc", {31'h0, out_trunc}, 32'h1);
        chk("sh2_addr", out_addr, 32'h0000_2000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // byte boundary: 0x80 signed truncates, 0xFFFFFF80 signed does not
        req(1'b1, 32'h0000_2101, 32'h0000_0080, 2'b00, 1'b1);
        step();
        req(1'b1, 32'h0000_2101, 32'hFFFF_FF80, 2'b00, 1'b1);
        step();
        req(1'b1, 32'h0000_2104, 32'hDEAD_BEEF, 2'b10, 1'b1);
        step();
        in_valid = 1'b0;
        chk("sb80_trunc", {31'h0, out_trunc}, 32'h1);
        chk("sb80_be", {28'h0, out_be}, 32'h2);
        out_ready = 1'b1;
        step();
        chk("sbff80_trunc", {31'h0, out_trunc}, 32'h0);
        chk("sbff80_wdata", out_wdata, 32'h8080_8080);
        step();
        chk("sw_wdata", out_wdata, 32'hDEAD_BEEF);
        chk("sw_be", {28'h0, out_be}, 32'hF);
        chk("sw_trunc", {31'h0, out_trunc}, 32'h0);
        step();
        out_ready = 1'b0;
        chk("drain_count", {29'h0, o_count}, 32'h0);

        // 3: rejects
        req(1'b1, 32'h0000_3001, 32'h1234_5678, 2'b10, 1'b0);
        step();
        in_valid = 1'b0;
        chk("sw_mis_err", {31'h0, misalign_err}, 32'h1);
        chk("sw_mis_valid", {31'h0, out_valid}, 32'h0);
        chk("sw_mis_count", {29'h0, o_count}, 32'h0);
        step();
        chk("sw_mis_pulse_end", {31'h0, misalign_err}, 32'h0);
        req(1'b1, 32'h0000_3001, 32'h1234_5678, 2'b01, 1'b0);
        step();
        in_valid = 1'b0;
        chk("sh_mis_err", {31'h0, misalign_err}, 32'h1);
        chk("sh_mis_count", {29'h0, o_count}, 32'h0);
        step();
        chk("sh_mis_pulse_end", {31'h0, misalign_err}, 32'h0);
        req(1'b1, 32'h0000_3000, 32'h1234_5678, 2'b11, 1'b0);
        step();
        in_valid = 1'b0;
        chk("rsv_err", {31'h0, misalign_err}, 32'h1);
        chk("rsv_valid", {31'h0, out_valid}, 32'h0);
        step();

        // 4: fill to full, hold a fifth request, then drain
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 32'h0000_4000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 2'b10, 1'b0);
            step();
        end
        req(1'b1, 32'h0000_4010, 32'h1111_0004, 2'b10, 1'b0);
        chk("full_count", {29'h0, o_count}, 32'h4);
        chk("full_in_ready", {31'h0, in_ready}, 32'h0);
        step();
        chk("full_hold_count", {29'h0, o_count}, 32'h4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("full_order_data", out_wdata, 32'h1111_0000 + 32'(i));
            chk("full_order_addr", out_addr, 32'h0000_4000 + 32'(4 * i));
            step();
            if (i == 0) begin
                chk("full_pop_only_count", {29'h0, o_count}, 32'h3);
            end
            if (i == 1) begin
                in_valid = 1'b0;
                chk("full_push_pop_count", {29'h0, o_count}, 32'h3);
            end
        end
        out_ready = 1'b0;
        chk("full_drained", {29'h0, o_count}, 32'h0);

        // 5: steady push+pop at count 2, wrapping pointers
        for (int k = 0; k < 2; k++) begin
            req(1'b1, 32'h0000_5000 + 32'(4 * k), 32'h5000_0000 + 32'(k), 2'b10, 1'b0);
            step();
        end
        out_ready = 1'b1;
        for (int k = 2; k < 18; k++) begin
            req(1'b1, 32'h0000_5000 + 32'(4 * k), 32'h5000_0000 + 32'(k), 2'b10, 1'b0);
            chk("wrap_head", out_wdata, 32'h5000_0000 + 32'(k - 2));
            step();
            chk("wrap_count", {29'h0, o_count}, 32'h2);
        end
        in_valid = 1'b0;
        chk("wrap_tail0", out_wdata, 32'h5000_0010);
        step();
        chk("wrap_tail1", out_wdata, 32'h5000_0011);
        step();
        out_ready = 1'b0;
        chk("wrap_empty", {31'h0, out_valid}, 32'h0);

        // 6: asynchronous reset with three queued entries
        for (int k = 0; k < 3; k++) begin
            req(1'b1, 32'h0000_6000 + 32'(4 * k), 32'h6000_0000 + 32'(k), 2'b10, 1'b0);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", {29'h0, o_count}, 32'h3);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("async_rst_count", {29'h0, o_count}, 32'h0);
        chk("async_rst_wdata", out_wdata, 32'h0);
        chk("async_rst_in_ready", {31'h0, in_ready}, 32'h1);
        #1;
        Rst_n = 1'b1;
        req(1'b1, 32'h0000_6002, 32'h0000_007F, 2'b00, 1'b1);
        step();
        in_valid = 1'b0;
        chk("post_rst_count", {29'h0, o_count}, 32'h1);
        chk("post_rst_be", {28'h0, out_be}, 32'h4);
        chk("post_rst_wdata", out_wdata, 32'h7F7F_7F7F);
        chk("post_rst_trunc", {31'h0, out_trunc}, 32'h0);
        chk("post_rst_addr", out_addr, 32'h0000_6000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
